// File: rtl/riscv_next_btb_strategy.sv
// Direct-mapped branch target buffer with 2-bit confidence counters for the riscv_next fetch path.
// The history port trains (PC -> target, ctr) pairs and the prefetch port reads back inject requests.
package riscv_next_pkg;
    typedef struct packed {
        logic is_branch;
        logic is_jal;
    } next_instr_signals_t;
endpackage

module riscv_next_btb_strategy
    import riscv_next_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int ENTRIES    = 16
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [ADDR_WIDTH-1:0]     i_pm_pc,
    input  logic                      i_pm_flush,
    output logic                      o_inject,
    output logic [ADDR_WIDTH-1:0]     o_inject_addr,
    input  logic [ADDR_WIDTH-1:0]     i_pc,
    input  logic                      i_flush,
    input  logic                      i_jump_branch,
    input  logic [ADDR_WIDTH-1:0]     i_jump_addr,
    input  next_instr_signals_t       i_signals,
    input  logic                      i_invalidate
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    logic [ENTRIES-1:0]    valid_q;
    logic [1:0]            ctr_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, i_pm_pc[1:0], i_pc[1:0]};

    // Lookup side
    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;

    assign rd_idx = i_pm_pc[IDX+1:2];
    assign rd_tag = i_pm_pc[ADDR_WIDTH-1:IDX+2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    always_comb begin
        o_inject      = rd_hit && ctr_q[rd_idx][1] && !i_pm_flush;
        o_inject_addr = o_inject ? target_q[rd_idx] : '0;
    end

    // Update side
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             upd;
    logic             ctr_wr;
    logic             tgt_wr;
    logic [1:0]       ctr_d;

    assign wr_idx = i_pc[IDX+1:2];
    assign wr_tag = i_pc[ADDR_WIDTH-1:IDX+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign upd    = !i_flush && (i_signals.is_branch || i_signals.is_jal);

    always_comb begin
        ctr_wr = 1'b0;
        tgt_wr = 1'b0;
        ctr_d  = ctr_q[wr_idx];
        if (upd && !i_invalidate) begin
            if (i_signals.is_jal) begin
                ctr_wr = 1'b1;
                tgt_wr = 1'b1;
                ctr_d  = 2'd3;
            end else if (i_jump_branch) begin
                ctr_wr = 1'b1;
                tgt_wr = 1'b1;
                if (wr_hit) begin
                    ctr_d = (ctr_q[wr_idx] == 2'd3) ? 2'd3 : ctr_q[wr_idx] + 2'd1;
                end else begin
                    ctr_d = 2'd2;
                end
            end else if (wr_hit) begin
                // Not-taken on a miss leaves the entry alone; on a hit it only decays.
                ctr_wr = 1'b1;
                ctr_d  = (ctr_q[wr_idx] == 2'd0) ? 2'd0 : ctr_q[wr_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'd0;
            end
        end else if (i_invalidate) begin
            valid_q <= '0;
        end else if (ctr_wr) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= ctr_d;
        end
    end

    // Tag/target carry no reset; they are meaningless while valid is clear.
    always_ff @(posedge clk) begin
        if (nrst && tgt_wr) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= i_jump_addr;
        end
    end

endmodule

// File: tb/tb_riscv_next_btb_strategy.sv
// Directed bench for riscv_next_btb_strategy: reset, JAL/branch learning, hysteresis, aliasing, invalidate.
module tb_riscv_next_btb_strategy;
    import riscv_next_pkg::*;

    logic                clk;
    logic                nrst;
    logic [15:0]         i_pm_pc;
    logic                i_pm_flush;
    logic                o_inject;
    logic [15:0]         o_inject_addr;
    logic [15:0]         i_pc;
    logic                i_flush;
    logic                i_jump_branch;
    logic [15:0]         i_jump_addr;
    next_instr_signals_t i_signals;
    logic                i_invalidate;

    int tests_run = 0;
    int tests_failed = 0;

    riscv_next_btb_strategy #(.ADDR_WIDTH(16), .ENTRIES(16)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_pm_pc       (i_pm_pc),
        .i_pm_flush    (i_pm_flush),
        .o_inject      (o_inject),
        .o_inject_addr (o_inject_addr),
        .i_pc          (i_pc),
        .i_flush       (i_flush),
        .i_jump_branch (i_jump_branch),
        .i_jump_addr   (i_jump_addr),
        .i_signals     (i_signals),
        .i_invalidate  (i_invalidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic [15:0] pc, input logic jal, input logic br,
                             input logic taken, input logic [15:0] addr,
                             input logic flush, input logic inval);
        i_pc                = pc;
        i_signals.is_jal    = jal;
        i_signals.is_branch = br;
        i_jump_branch       = taken;
        i_jump_addr         = addr;
        i_flush             = flush;
        i_invalidate        = inval;
    endtask

    task automatic idle_upd();
        drive_upd(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // One full update cycle: drive, clock edge, back to idle.
    task automatic upd(input logic [15:0] pc, input logic jal, input logic br,
                       input logic taken, input logic [15:0] addr);
        drive_upd(pc, jal, br, taken, addr, 1'b0, 1'b0);
        step();
        idle_upd();
    endtask

    task automatic check(input string tag, input logic [15:0] pc, input logic flush,
                         input logic exp_inj, input logic [15:0] exp_addr);
        i_pm_pc    = pc;
        i_pm_flush = flush;
        #1;
        tests_run++;
        assert (o_inject === exp_inj) else begin
            tests_failed++;
            $error("FAIL %s pc=%h inject got %b expected %b", tag, pc, o_inject, exp_inj);
        end
        tests_run++;
        assert (o_inject_addr === exp_addr) else begin
            tests_failed++;
            $error("FAIL %s pc=%h addr got %h expected %h", tag, pc, o_inject_addr, exp_addr);
        end
        $display("[TB] %s pc=%h flush=%b -> inject=%b addr=%h", tag, pc, flush, o_inject, o_inject_addr);
    endtask

    initial begin
        nrst       = 1'b0;
        i_pm_pc    = 16'h0000;
        i_pm_flush = 1'b0;
        idle_upd();
        step();
        step();
        check("por", 16'h0040, 1'b0, 1'b0, 16'h0000);
        nrst = 1'b1;
        step();

        // Train something, then reset mid-run with an update in flight.
        upd(16'h0040, 1'b1, 1'b0, 1'b1, 16'h0100);
        check("pre_rst", 16'h0040, 1'b0, 1'b1, 16'h0100);
        #2;
        nrst = 1'b0;
        check("rst_async", 16'h0040, 1'b0, 1'b0, 16'h0000);
        drive_upd(16'h0080, 1'b1, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b0);
        step();
        check("rst_held", 16'h0080, 1'b0, 1'b0, 16'h0000);
        step();
        idle_upd();
        #2;
        nrst = 1'b1;
        for (int a = 0; a <= 16'h00FC; a += 4) begin
            check("rst_sweep", a[15:0], 1'b0, 1'b0, 16'h0000);
        end
        step();

        // JAL learning with no same-cycle bypass.
        drive_upd(16'h0040, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        check("jal_same_cyc", 16'h0040, 1'b0, 1'b0, 16'h0000);
        step();
        idle_upd();
        check("jal_next_cyc", 16'h0040, 1'b0, 1'b1, 16'h0100);
        check("jal_pm_flush", 16'h0040, 1'b1, 1'b0, 16'h0000);

        // Branch hysteresis at 0x0080 (aliases onto 0x0040's entry, so first taken allocates).
        upd(16'h0080, 1'b0, 1'b1, 1'b1, 16'h0020);
        check("hyst_t1_c2", 16'h0080, 1'b0, 1'b1, 16'h0020);
        upd(16'h0080, 1'b0, 1'b1, 1'b1, 16'h0020);
        check("hyst_t2_c3", 16'h0080, 1'b0, 1'b1, 16'h0020);
        upd(16'h0080, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("hyst_n1_c2", 16'h0080, 1'b0, 1'b1, 16'h0020);
        upd(16'h0080, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("hyst_n2_c1", 16'h0080, 1'b0, 1'b0, 16'h0000);
        upd(16'h0080, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("hyst_n3_c0", 16'h0080, 1'b0, 1'b0, 16'h0000);
        upd(16'h0080, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("hyst_n4_c0", 16'h0080, 1'b0, 1'b0, 16'h0000);
        upd(16'h0080, 1'b0, 1'b1, 1'b1, 16'h0020);
        check("hyst_t3_c1", 16'h0080, 1'b0, 1'b0, 16'h0000);
        upd(16'h0080, 1'b0, 1'b1, 1'b1, 16'h0020);
        check("hyst_t4_c2", 16'h0080, 1'b0, 1'b1, 16'h0020);

        // Aliasing: both PCs map to index 0.
        upd(16'h0040, 1'b1, 1'b0, 1'b1, 16'h0100);
        check("alias_jal", 16'h0040, 1'b0, 1'b1, 16'h0100);
        upd(16'h0080, 1'b0, 1'b1, 1'b1, 16'h0200);
        check("alias_old", 16'h0040, 1'b0, 1'b0, 16'h0000);
        check("alias_new", 16'h0080, 1'b0, 1'b1, 16'h0200);

        // Squash and no-op cases.
        drive_upd(16'h0104, 1'b0, 1'b1, 1'b1, 16'h0600, 1'b1, 1'b0);
        step();
        idle_upd();
        check("sq_flush", 16'h0104, 1'b0, 1'b0, 16'h0000);
        upd(16'h0108, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("sq_nt_miss", 16'h0108, 1'b0, 1'b0, 16'h0000);
        upd(16'h0108, 1'b0, 1'b1, 1'b1, 16'h0700);
        check("sq_nt_then_t", 16'h0108, 1'b0, 1'b1, 16'h0700);
        upd(16'h010C, 1'b0, 1'b0, 1'b1, 16'h0800);
        check("sq_nonbranch", 16'h010C, 1'b0, 1'b0, 16'h0000);
        upd(16'h0110, 1'b1, 1'b1, 1'b1, 16'h0900);
        upd(16'h0110, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("both_as_jal", 16'h0110, 1'b0, 1'b1, 16'h0900);

        // Invalidate.
        upd(16'h0004, 1'b1, 1'b0, 1'b1, 16'h0400);
        upd(16'h0008, 1'b1, 1'b0, 1'b1, 16'h0404);
        upd(16'h000C, 1'b1, 1'b0, 1'b1, 16'h0408);
        upd(16'h0010, 1'b1, 1'b0, 1'b1, 16'h040C);
        check("inv_pre_a", 16'h0004, 1'b0, 1'b1, 16'h0400);
        check("inv_pre_d", 16'h0010, 1'b0, 1'b1, 16'h040C);
        drive_upd(16'h00C0, 1'b1, 1'b0, 1'b1, 16'h0500, 1'b0, 1'b1);
        step();
        idle_upd();
        check("inv_a", 16'h0004, 1'b0, 1'b0, 16'h0000);
        check("inv_b", 16'h0008, 1'b0, 1'b0, 16'h0000);
        check("inv_c", 16'h000C, 1'b0, 1'b0, 16'h0000);
        check("inv_d", 16'h0010, 1'b0, 1'b0, 16'h0000);
        check("inv_c0", 16'h00C0, 1'b0, 1'b0, 16'h0000);
        drive_upd(16'h00C0, 1'b1, 1'b0, 1'b1, 16'h0500, 1'b0, 1'b0);
        check("retrain_same", 16'h00C0, 1'b0, 1'b0, 16'h0000);
        step();
        idle_upd();
        check("retrain_next", 16'h00C0, 1'b0, 1'b1, 16'h0500);
        check("retrain_other", 16'h0004, 1'b0, 1'b0, 16'h0000);
        // JAL sets ctr=3: one not-taken still injects, a second does not.
        upd(16'h00C0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("jal_ctr3_n1", 16'h00C0, 1'b0, 1'b1, 16'h0500);
        upd(16'h00C0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("jal_ctr3_n2", 16'h00C0, 1'b0, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/riscv_next_btb_strategy.md
# riscv_next_btb_strategy

Branch-target-buffer jump-prediction strategy for the `riscv_next` fetch path. It consumes resolved control-flow outcomes from the history port and learns `(PC -> target, 2-bit confidence)` pairs. It answers prefetch-stage lookups with an inject request and address toward the next-PC mux. It is the learning and answering end of the strategy history and from-PM signal sets, and is compiled only under `USE_JUMP_PREDICTOR`.

## Interface
**Parameters**
- `ADDR_WIDTH`, 16: PC width. PCs are byte addresses; bits [1:0] are ignored.
- `ENTRIES`, 16: BTB depth, a power of two ≥ 2. `IDX = $clog2(ENTRIES)`.

**Ports**
- `clk`  in  1: the single clock.
- `nrst`  in  1: asynchronous, active-low reset.
- `i_pm_pc`  in  ADDR_WIDTH: prefetch-stage PC to look up.
- `i_pm_flush`  in  1: prefetch stage squashed; masks the inject.
- `o_inject`  out  1: predicted-taken hit for `i_pm_pc`.
- `o_inject_addr`  out  ADDR_WIDTH: predicted target. Zero when `o_inject`=0.
- `i_pc`  in  ADDR_WIDTH: PC of the resolved (history) instruction.
- `i_flush`  in  1: history instruction squashed; no update.
- `i_jump_branch`  in  1: history instruction actually redirected (taken).
- `i_jump_addr`  in  ADDR_WIDTH: actual target.
- `i_signals`  in  next_instr_signals_t: decoded class. Only the members `is_branch` and `is_jal` are consumed.
- `i_invalidate`  in  1: clear all entries (fence.i / context change).

## Operation
- **Storage:** `ENTRIES` entries, each holding `valid`, `tag[ADDR_WIDTH-IDX-3:0]`, `target[ADDR_WIDTH-1:0]` and `ctr[1:0]`.
  - `index = pc[IDX+1:2]`, `tag = pc[ADDR_WIDTH-1:IDX+2]`.
- **Lookup (combinational from registered state):**
  - `hit = valid[idx] && tag==tag(i_pm_pc)`.
  - `o_inject = hit && ctr[idx]>=2 && !i_pm_flush`.
  - `o_inject_addr = o_inject ? target[idx] : 0`.
- **Update:** qualifies when `upd = !i_flush && (is_branch || is_jal)`, evaluated on the entry at `index(i_pc)`. Let `h` be the tag match for `i_pc`.
  - **JAL:** write `valid=1`, `tag`, `target=i_jump_addr`, `ctr=3`. This applies hit or miss.
  - **Branch taken, `h`:** `ctr = min(ctr+1, 3)`, `target=i_jump_addr`.
  - **Branch taken, miss:** allocate or replace with `valid=1`, `tag`, `target=i_jump_addr`, `ctr=2`.
  - **Branch not taken, `h`:** `ctr = max(ctr-1, 0)`. The entry stays valid.
  - **Branch not taken, miss:** no change.
  - **`is_branch` and `is_jal` both set:** treat as JAL.
- **`i_invalidate`:** clears every `valid` at the next edge. When it coincides with an update, invalidate wins and the update is dropped. `tag`, `target` and `ctr` are not cleared.
- The history-side port only writes and the PM-side port only reads. They operate independently every cycle.

## Timing
- **Reset (`nrst`=0, asynchronous):** all `valid`=0 and all `ctr`=0.
  - `o_inject`=0 and `o_inject_addr`=0 immediately, and for as long as reset is held.
  - Reset mid-update discards the update.
- **Lookup latency:** 0 cycles. Outputs are a function of the current `i_pm_pc`/`i_pm_flush` and the state.
- **Update latency:** 1 cycle. A write becomes visible to lookups in the cycle after the qualifying edge.
- **Same-cycle update and lookup of the same PC:** the lookup returns the old contents. There is no bypass.
- **Counter boundaries:**
  - Saturates at 3 on taken and at 0 on not-taken, with no wrap.
  - Threshold: 2 = weakly taken (injects), 1 = weakly not taken (no inject).
- **Aliasing:** a tag mismatch on a taken branch or JAL overwrites the entry. There is no replacement choice (direct-mapped).

## Test plan
- **Reset:** assert `nrst`=0 mid-run, then release and sweep `i_pm_pc` 0x0000–0x00FC -> `o_inject`=0 and `o_inject_addr`=0x0000 throughout.
- **JAL learning:** update a JAL at `i_pc`=0x0040 with `i_jump_addr`=0x0100.
  - `i_pm_pc`=0x0040 in the same cycle -> `o_inject`=0.
  - Next cycle -> `o_inject`=1, `o_inject_addr`=0x0100.
  - With `i_pm_flush`=1 -> `o_inject`=0, `o_inject_addr`=0.
- **Branch hysteresis:** branch at 0x0080 with target 0x0020. Expected `o_inject` at `i_pm_pc`=0x0080 after each step:
  - taken -> 1 (ctr 2)
  - taken -> 1 (ctr 3)
  - not taken ×3 -> 1, 0, 0 (ctr 2, 1, 0)
  - not taken -> 0 (ctr stays 0)
  - taken -> 0 (ctr 1)
  - taken -> 1 (ctr 2)
- **Aliasing (`ENTRIES`=16):** JAL 0x0040→0x0100, then taken branch 0x0080→0x0200. Lookup 0x0040 -> `o_inject`=0; lookup 0x0080 -> `o_inject`=1 with addr 0x0200.
- **Squash and no-op cases:**
  - Taken branch with `i_flush`=1 -> no entry created.
  - Not-taken branch at an untouched PC -> no entry created.
  - Non-branch with `i_jump_branch`=1 -> no entry created.
- **Invalidate:** train 4 PCs.
  - Assert `i_invalidate` in the same cycle as a JAL update at 0x00C0 -> all 5 lookups return `o_inject`=0 on the next cycle.
  - Retrain 0x00C0 -> it injects one cycle later.
